// File: rtl/pellet_board_ctrl.sv
// Pellet bitmap owner for the maze: arbitrates one access slot per cycle between
// the eat path and the renderer read path, and runs the LOAD/PLAY/CLEAR level cycle.
module pellet_board_ctrl #(
    parameter logic [63:0] INIT_MAP   = 64'h00_78_48_7E_42_42_7E_00,
    parameter int          SCORE_W    = 8,
    parameter int          PELLET_PTS = 1,
    parameter int          CLEAR_HOLD = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               eat_req,
    input  logic [2:0]         eat_row,
    input  logic [2:0]         eat_col,
    output logic               eat_gnt,
    output logic               eat_done,
    output logic               eat_hit,
    input  logic               rd_req,
    input  logic [2:0]         rd_row,
    input  logic [2:0]         rd_col,
    output logic               rd_gnt,
    output logic               rd_valid,
    output logic               rd_data,
    output logic [0:63]        pellet_arr,
    output logic [SCORE_W-1:0] score,
    output logic [6:0]         remaining,
    output logic [3:0]         level,
    output logic               level_clear
);

    typedef enum logic [1:0] {LOAD, PLAY, CLEAR} state_t;

    function automatic logic [6:0] popcount(input logic [63:0] m);
        logic [6:0] c;
        c = '0;
        for (int i = 0; i < 64; i++) c = c + {6'd0, m[i]};
        return c;
    endfunction

    localparam int               HOLD_W    = (CLEAR_HOLD > 1) ? $clog2(CLEAR_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(CLEAR_HOLD - 1);
    localparam logic [SCORE_W:0]  PTS_EXT   = (SCORE_W + 1)'(PELLET_PTS);
    localparam logic [6:0]        INIT_CNT  = popcount(INIT_MAP);

    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a);
        logic [SCORE_W:0] s;
        s = {1'b0, a} + PTS_EXT;
        return s[SCORE_W] ? {SCORE_W{1'b1}} : s[SCORE_W-1:0];
    endfunction

    state_t            state;
    state_t            state_next;
    logic              ptr;
    logic [HOLD_W-1:0] hold_cnt;
    logic [5:0]        eat_idx;
    logic [5:0]        rd_idx;
    logic              eat_bit;
    logic              rd_bit;
    logic              eat_ok;
    logic              rd_ok;
    logic              eat_take;
    logic              hold_done;

    assign eat_idx   = {eat_row, eat_col};
    assign rd_idx    = {rd_row, rd_col};
    assign eat_bit   = pellet_arr[eat_idx];
    assign rd_bit    = pellet_arr[rd_idx];
    assign hold_done = (state == CLEAR) && (hold_cnt == HOLD_LAST);

    // Eats only in PLAY; reads in PLAY and CLEAR. ptr picks the winner on contention.
    assign eat_ok   = eat_req && (state == PLAY);
    assign rd_ok    = rd_req && ((state == PLAY) || (state == CLEAR));
    assign eat_gnt  = eat_ok && (!rd_ok || !ptr);
    assign rd_gnt   = rd_ok && (!eat_ok || ptr);
    assign eat_take = eat_gnt && eat_bit;

    assign level_clear = (state == CLEAR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= LOAD;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            LOAD:  state_next = PLAY;
            PLAY:  if ((remaining == 7'd0) || (eat_take && remaining == 7'd1))
                       state_next = CLEAR;
            CLEAR: if (hold_done) state_next = LOAD;
            default: state_next = LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr        <= 1'b0;
            hold_cnt   <= '0;
            level      <= 4'd0;
            eat_done   <= 1'b0;
            eat_hit    <= 1'b0;
            rd_valid   <= 1'b0;
            rd_data    <= 1'b0;
            pellet_arr <= '0;
            score      <= '0;
            remaining  <= 7'd0;
        end else begin
            if (eat_ok && rd_ok) ptr <= ~ptr;
            hold_cnt <= (state == CLEAR) ? hold_cnt + HOLD_W'(1) : '0;
            if (hold_done) level <= level + 4'd1;

            eat_done <= eat_gnt;
            eat_hit  <= eat_take;
            rd_valid <= rd_gnt;
            // Read returns the bitmap as it stood before this cycle's commit
            rd_data  <= rd_gnt && (state != CLEAR) && rd_bit;

            if (state == LOAD) begin
                pellet_arr <= INIT_MAP;
                remaining  <= INIT_CNT;
            end else if (eat_take) begin
                pellet_arr[eat_idx] <= 1'b0;
                remaining           <= remaining - 7'd1;
                score               <= sat_add(score);
            end
        end
    end

endmodule

// File: tb/tb_pellet_board_ctrl.sv
// Directed bench for pellet_board_ctrl: level cycle, arbitration, reset in CLEAR,
// and score saturation on a narrow-score instance.
module tb_pellet_board_ctrl;

    localparam logic [63:0] MAP = 64'h00_78_48_7E_42_42_7E_00;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, eat_req, rd_req;
    logic [2:0]  eat_row, eat_col, rd_row, rd_col;
    logic        eat_gnt, eat_done, eat_hit, rd_gnt, rd_valid, rd_data, level_clear;
    logic [0:63] pellet_arr;
    logic [7:0]  score;
    logic [6:0]  remaining;
    logic [3:0]  level;

    logic        s_reset, s_eat_req, s_rd_req;
    logic [2:0]  s_eat_row, s_eat_col, s_rd_row, s_rd_col;
    logic        s_eat_gnt, s_eat_done, s_eat_hit, s_rd_gnt, s_rd_valid, s_rd_data, s_level_clear;
    logic [0:63] s_pellet_arr;
    logic [3:0]  s_score;
    logic [6:0]  s_remaining;
    logic [3:0]  s_level;

    pellet_board_ctrl dut (
        .clk(clk), .reset(reset),
        .eat_req(eat_req), .eat_row(eat_row), .eat_col(eat_col),
        .eat_gnt(eat_gnt), .eat_done(eat_done), .eat_hit(eat_hit),
        .rd_req(rd_req), .rd_row(rd_row), .rd_col(rd_col),
        .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data),
        .pellet_arr(pellet_arr), .score(score), .remaining(remaining),
        .level(level), .level_clear(level_clear)
    );

    pellet_board_ctrl #(.SCORE_W(4), .PELLET_PTS(5)) dut_sat (
        .clk(clk), .reset(s_reset),
        .eat_req(s_eat_req), .eat_row(s_eat_row), .eat_col(s_eat_col),
        .eat_gnt(s_eat_gnt), .eat_done(s_eat_done), .eat_hit(s_eat_hit),
        .rd_req(s_rd_req), .rd_row(s_rd_row), .rd_col(s_rd_col),
        .rd_gnt(s_rd_gnt), .rd_valid(s_rd_valid), .rd_data(s_rd_data),
        .pellet_arr(s_pellet_arr), .score(s_score), .remaining(s_remaining),
        .level(s_level), .level_clear(s_level_clear)
    );

    int          checks = 0;
    int          failures = 0;
    logic [0:63] model;
    int          exp_rem;
    int          exp_score;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_eat(input logic [2:0] r, input logic [2:0] c, input logic hit, input string tag);
        eat_row = r; eat_col = c; eat_req = 1'b1;
        #1;
        chk({tag, "_gnt"}, eat_gnt, 1);
        @(posedge clk);
        #1;
        eat_req = 1'b0;
        chk({tag, "_done"}, eat_done, 1);
        chk({tag, "_hit"}, eat_hit, hit);
    endtask

    // Eats every pellet still set in the bench's model, in index order.
    task automatic eat_all(input string tag);
        for (int i = 0; i < 64; i++) begin
            if (model[i]) begin
                logic [5:0] idx;
                idx = 6'(i);
                do_eat(idx[5:3], idx[2:0], 1'b1, $sformatf("%s_%0d", tag, i));
                model[i] = 1'b0;
                exp_rem--;
                exp_score++;
                chk($sformatf("%s_rem_%0d", tag, i), remaining, 64'(exp_rem));
                chk($sformatf("%s_score_%0d", tag, i), score, 64'(exp_score));
            end
        end
        chk({tag, "_clear"}, level_clear, 1);
        chk({tag, "_arr_empty"}, pellet_arr, 64'h0);
    endtask

    initial begin
        reset = 1'b1; s_reset = 1'b1;
        eat_req = 0; rd_req = 0; eat_row = 0; eat_col = 0; rd_row = 0; rd_col = 0;
        s_eat_req = 0; s_rd_req = 0; s_eat_row = 0; s_eat_col = 0; s_rd_row = 0; s_rd_col = 0;

        // Reset state, with requests pending
        repeat (2) @(posedge clk);
        #1;
        eat_req = 1; rd_req = 1;
        #1;
        chk("rst_eat_gnt", eat_gnt, 0);
        chk("rst_rd_gnt", rd_gnt, 0);
        chk("rst_arr", pellet_arr, 64'h0);
        chk("rst_score", score, 0);
        chk("rst_rem", remaining, 0);
        chk("rst_level", level, 0);
        chk("rst_clear", level_clear, 0);
        chk("rst_done", eat_done, 0);
        chk("rst_valid", rd_valid, 0);

        reset = 0;
        #1;
        chk("load_eat_gnt", eat_gnt, 0);
        chk("load_rd_gnt", rd_gnt, 0);
        tick();
        eat_req = 0; rd_req = 0;
        chk("play_arr", pellet_arr, MAP);
        chk("play_rem", remaining, 22);
        chk("play_score", score, 0);
        chk("play_level", level, 0);

        // Single eats: hit then miss on the same cell
        do_eat(3'd1, 3'd1, 1'b1, "eat11");
        chk("eat11_score", score, 1);
        chk("eat11_rem", remaining, 21);
        chk("eat11_bit9", pellet_arr[9], 0);
        do_eat(3'd1, 3'd1, 1'b0, "eat11b");
        chk("eat11b_score", score, 1);
        chk("eat11b_rem", remaining, 21);

        // Contention: grants alternate eat, rd, eat, rd
        eat_row = 1; eat_col = 2; eat_req = 1;
        rd_row = 1;  rd_col = 2;  rd_req = 1;
        #1;
        chk("arb0_eat", eat_gnt, 1);
        chk("arb0_rd", rd_gnt, 0);
        tick();
        chk("arb0_hit", eat_hit, 1);
        eat_col = 3;
        #1;
        chk("arb1_eat", eat_gnt, 0);
        chk("arb1_rd", rd_gnt, 1);
        tick();
        chk("arb1_valid", rd_valid, 1);
        chk("arb1_data", rd_data, 0);
        rd_row = 2; rd_col = 1;
        #1;
        chk("arb2_eat", eat_gnt, 1);
        chk("arb2_rd", rd_gnt, 0);
        tick();
        chk("arb2_hit", eat_hit, 1);
        eat_col = 4;
        #1;
        chk("arb3_eat", eat_gnt, 0);
        chk("arb3_rd", rd_gnt, 1);
        tick();
        eat_req = 0; rd_req = 0;
        chk("arb3_valid", rd_valid, 1);
        chk("arb3_data", rd_data, 1);
        chk("arb_score", score, 3);
        chk("arb_rem", remaining, 19);

        // Clear the level
        model = MAP;
        model[9] = 0; model[10] = 0; model[11] = 0;
        exp_rem = 19; exp_score = 3;
        eat_all("lvl0");

        eat_row = 0; eat_col = 0; eat_req = 1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("hold%0d_clear", k), level_clear, 1);
            if (k == 1) begin
                rd_row = 3; rd_col = 3; rd_req = 1;
            end
            #1;
            chk($sformatf("hold%0d_eat_gnt", k), eat_gnt, 0);
            if (k == 1) chk("hold_rd_gnt", rd_gnt, 1);
            tick();
            if (k == 1) begin
                chk("hold_rd_valid", rd_valid, 1);
                chk("hold_rd_data", rd_data, 0);
                rd_req = 0;
            end
        end
        chk("lvl1_load_clear", level_clear, 0);
        chk("lvl1_load_eat_gnt", eat_gnt, 0);
        chk("lvl1_level", level, 1);
        tick();
        chk("lvl1_arr", pellet_arr, MAP);
        chk("lvl1_rem", remaining, 22);
        chk("lvl1_score", score, 22);
        chk("lvl1_eat_gnt", eat_gnt, 1);
        tick();
        eat_req = 0;
        chk("lvl1_miss_done", eat_done, 1);
        chk("lvl1_miss_hit", eat_hit, 0);

        // Clear again, then reset in the second CLEAR cycle
        model = MAP; exp_rem = 22; exp_score = 22;
        eat_all("lvl1");
        tick();
        chk("clr2_clear", level_clear, 1);
        chk("clr2_score", score, 44);
        reset = 1;
        #1;
        chk("rclr_clear", level_clear, 0);
        chk("rclr_score", score, 0);
        chk("rclr_rem", remaining, 0);
        chk("rclr_level", level, 0);
        chk("rclr_arr", pellet_arr, 64'h0);
        chk("rclr_done", eat_done, 0);
        chk("rclr_hit", eat_hit, 0);
        chk("rclr_rdata", rd_data, 0);
        tick();
        reset = 0;
        tick();
        chk("rplay_level", level, 0);
        chk("rplay_rem", remaining, 22);
        chk("rplay_arr", pellet_arr, MAP);
        chk("rplay_clear", level_clear, 0);
        do_eat(3'd2, 3'd1, 1'b1, "rplay_eat");
        chk("rplay_score", score, 1);

        // Narrow saturating score: 4 bits, 5 points per pellet
        s_reset = 0;
        tick();
        for (int k = 0; k < 4; k++) begin
            logic [3:0] exp_s;
            exp_s = (k < 2) ? 4'(5 * (k + 1)) : 4'd15;
            s_eat_row = 1; s_eat_col = 3'(k + 1); s_eat_req = 1;
            #1;
            chk($sformatf("sat%0d_gnt", k), s_eat_gnt, 1);
            tick();
            s_eat_req = 0;
            chk($sformatf("sat%0d_hit", k), s_eat_hit, 1);
            chk($sformatf("sat%0d_score", k), s_score, 64'(exp_s));
            chk($sformatf("sat%0d_rem", k), s_remaining, 64'(21 - k));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
